// File: rtl/bf16_mul_pipe.sv
// bf16_mul_pipe: two-stage pipelined bfloat16 multiplier feeding BF_adder.
// Stage 1 unpacks the operands, forms the sign, the biased exponent sum, the
// 8x8 significand product and the special-value class. Stage 2 normalises,
// truncates and resolves specials into the registered product.
// A single advance enable moves both stages together, giving full
// backpressure without collapsing bubbles.
module bf16_mul_pipe #(
  parameter int BIAS       = 127,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] product
);

  logic en;

  logic [7:0] a_exp, b_exp;
  logic [6:0] a_frac, b_frac;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q, s1_sign_d;
  logic signed [9:0] s1_esum_q, s1_esum_d;
  logic [15:0]       s1_mprod_q, s1_mprod_d;
  logic              s1_nan_q, s1_nan_d;
  logic              s1_inf_q, s1_inf_d;
  logic              s1_zero_q, s1_zero_d;

  logic              out_valid_q, out_valid_d;
  logic [15:0]       product_q, product_d;

  logic signed [9:0] exp_n;
  logic [6:0]        frac_n;
  logic [15:0]       result;
  logic              unused_low_bits;

  // Both stages advance together whenever the output slot is free or draining.
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign product   = product_q;

  assign a_exp  = a[14:7];
  assign b_exp  = b[14:7];
  assign a_frac = a[6:0];
  assign b_frac = b[6:0];

  // Stage 1: unpack, classify and multiply significands.
  always_comb begin
    a_nan  = (&a_exp) && (|a_frac);
    b_nan  = (&b_exp) && (|b_frac);
    a_inf  = (&a_exp) && !(|a_frac);
    b_inf  = (&b_exp) && !(|b_frac);
    // Subnormals are flushed, so an all-zero exponent counts as zero.
    a_zero = !(|a_exp);
    b_zero = !(|b_exp);

    s1_valid_d = in_valid;
    s1_sign_d  = a[15] ^ b[15];
    s1_esum_d  = $signed({2'b00, a_exp} + {2'b00, b_exp} - 10'(BIAS));
    s1_mprod_d = 16'({1'b1, a_frac}) * 16'({1'b1, b_frac});
    // Inf * zero is folded into the NaN flag so stage 2 needs only a priority chain.
    s1_nan_d   = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    s1_inf_d   = a_inf || b_inf;
    s1_zero_d  = a_zero || b_zero;
  end

  // Stage 1 register: loads every enabled cycle, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_esum_q  <= '0;
      s1_mprod_q <= '0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_esum_q  <= s1_esum_d;
      s1_mprod_q <= s1_mprod_d;
      s1_nan_q   <= s1_nan_d;
      s1_inf_q   <= s1_inf_d;
      s1_zero_q  <= s1_zero_d;
    end
  end

  // Stage 2: normalise by at most one place, truncate, then apply specials.
  always_comb begin
    exp_n  = s1_esum_q + $signed({9'd0, s1_mprod_q[15]});
    frac_n = s1_mprod_q[15] ? s1_mprod_q[14:8] : s1_mprod_q[13:7];
    if (s1_nan_q)
      result = 16'h7FC0;
    else if (s1_inf_q)
      result = {s1_sign_q, 8'hFF, 7'h00};
    else if (s1_zero_q)
      result = {s1_sign_q, 15'h0000};
    else if (exp_n >= 10'sd255)
      result = {s1_sign_q, 8'hFF, 7'h00};
    else if (exp_n <= 10'sd0)
      result = {s1_sign_q, 15'h0000};
    else
      result = {s1_sign_q, exp_n[7:0], frac_n};

    out_valid_d = s1_valid_q;
    // A bubble leaves the last product in place rather than loading stale data.
    product_d   = s1_valid_q ? result : product_q;
  end

  // Bits below the truncation point never reach the result.
  assign unused_low_bits = ^s1_mprod_q[6:0];

  // Output register: holds product and valid while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      product_q   <= 16'h0000;
    end else if (en) begin
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
    end
  end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Self-checking bench for bf16_mul_pipe: directed vectors with literal
// expectations, an arithmetic reference model fed through an in-order
// scoreboard, backpressure, throughput and mid-stream reset scenarios.
module tb_bf16_mul_pipe;

  localparam int BIAS = 127;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int emitted = 0;
  int emit_at[$];
  logic [15:0] exp_q[$];

  logic [15:0] tA[128];
  logic [15:0] tB[128];

  bf16_mul_pipe #(.BIAS(BIAS), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decode to integers, normalise the full product by shifting
  // until an 8-bit significand remains, then apply the special-value rules.
  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int ex, ey, fx, fy, p, sh, e;
    logic s;
    bit nx, ny, ix, iy, zx, zy;
    ex = int'(x[14:7]); ey = int'(y[14:7]);
    fx = int'(x[6:0]);  fy = int'(y[6:0]);
    s  = x[15] ^ y[15];
    nx = (ex == 255) && (fx != 0); ny = (ey == 255) && (fy != 0);
    ix = (ex == 255) && (fx == 0); iy = (ey == 255) && (fy == 0);
    zx = (ex == 0);                zy = (ey == 0);
    if (nx || ny) return 16'h7FC0;
    if (ix || iy) begin
      if (zx || zy) return 16'h7FC0;
      return {s, 8'hFF, 7'h00};
    end
    if (zx || zy) return {s, 15'h0000};
    p  = (128 + fx) * (128 + fy);
    sh = 0;
    while (p >= 256) begin
      p  = p >> 1;
      sh = sh + 1;
    end
    e = ex + ey - BIAS - 7 + sh;
    if (e >= 255) return {s, 8'hFF, 7'h00};
    if (e <= 0)   return {s, 15'h0000};
    return {s, e[7:0], p[6:0]};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out (cycle %0d)", name, cyc);
  endtask

  // Scoreboard: pushes the model result on every accept, pops and compares
  // on every emit, and checks product/valid are held across stalls.
  task automatic monitor();
    logic [15:0] prev_p;
    logic [15:0] e;
    bit prev_hold;
    prev_hold = 0;
    prev_p = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", {15'd0, out_valid}, 16'd1);
          chk("hold_product", product, prev_p);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            timeout("spurious_output");
          end else begin
            e = exp_q.pop_front();
            chk("stream_product", product, e);
            emitted++;
            emit_at.push_back(cyc);
          end
        end
        if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b));
        prev_hold = out_valid && !out_ready;
        prev_p = product;
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) timeout("drain");
  endtask

  task automatic send_one(input logic [15:0] x, input logic [15:0] y, input logic [15:0] req);
    int t;
    bit got;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; out_ready = 1'b1;
    @(negedge clk);
    chk("accept_ready", {15'd0, in_ready}, 16'd1);
    t = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) timeout("directed_out_valid");
    else begin
      chk("latency", 16'(cyc - t), 16'd2);
      chk("directed_product", product, req);
    end
  endtask

  typedef struct { logic [15:0] x; logic [15:0] y; logic [15:0] r; } vec_t;
  vec_t dirv[12];

  logic [15:0] bpA[4];
  logic [15:0] bpB[4];

  initial begin
    int idx, base, stalls;
    fork monitor(); join_none

    dirv[0]  = '{16'h3F80, 16'h3F80, 16'h3F80};
    dirv[1]  = '{16'h3FC0, 16'h3FC0, 16'h4010};
    dirv[2]  = '{16'hC000, 16'h4040, 16'hC0C0};
    dirv[3]  = '{16'h3F81, 16'h3F81, 16'h3F82};
    dirv[4]  = '{16'h4000, 16'h3FC0, 16'h4040};
    dirv[5]  = '{16'h7F00, 16'h4000, 16'h7F80};
    dirv[6]  = '{16'h7F80, 16'h0000, 16'h7FC0};
    dirv[7]  = '{16'hFF80, 16'h3F80, 16'hFF80};
    dirv[8]  = '{16'h7FC1, 16'h3F80, 16'h7FC0};
    dirv[9]  = '{16'h8000, 16'h3F80, 16'h8000};
    dirv[10] = '{16'h0001, 16'h3F80, 16'h0000};
    dirv[11] = '{16'h0080, 16'h0080, 16'h0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_product", product, 16'h0000);
    chk("reset_in_ready", {15'd0, in_ready}, 16'd1);

    // Pin the model against hand-computed values
    for (int i = 0; i < 12; i++) chk("model_literal", ref_mul(dirv[i].x, dirv[i].y), dirv[i].r);

    // Directed vectors through the DUT
    for (int i = 0; i < 12; i++) send_one(dirv[i].x, dirv[i].y, dirv[i].r);
    drain();

    // Backpressure: four pairs offered with out_ready low
    bpA[0] = 16'h3FC0; bpB[0] = 16'h3FC0;
    bpA[1] = 16'hC000; bpB[1] = 16'h4040;
    bpA[2] = 16'h3F81; bpB[2] = 16'h3F81;
    bpA[3] = 16'h4000; bpB[3] = 16'h3FC0;
    base = emitted;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = (idx < 4);
      if (idx < 4) begin a = bpA[idx]; b = bpB[idx]; end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (c >= 2) begin
        chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
        chk("bp_product", product, 16'h4010);
      end
    end
    chk("bp_accepted", 16'(idx), 16'd2);
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = bpA[idx]; b = bpB[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
    chk("bp_emitted", 16'(emitted - base), 16'd4);

    // Throughput: 128 back-to-back pairs, mostly normals plus some specials
    for (int i = 0; i < 128; i++) begin
      tA[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 7'($urandom_range(0, 127))};
      tB[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 7'($urandom_range(0, 127))};
    end
    tA[10] = 16'h7F80; tB[10] = 16'h3F80;
    tA[20] = 16'h7F00; tB[20] = 16'h7F00;
    tA[30] = 16'h0080; tB[30] = 16'h0100;
    tA[40] = 16'h7FC1; tB[40] = 16'h0000;
    tA[50] = 16'h0005; tB[50] = 16'hFF80;
    tA[60] = 16'h3FFF; tB[60] = 16'h3FFF;
    base = emitted;
    idx = 0;
    stalls = 0;
    for (int c = 0; c < 300 && idx < 128; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = tA[idx]; b = tB[idx];
      @(negedge clk);
      if (in_ready) idx++;
      else stalls++;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
    chk("tp_stalls", 16'(stalls), 16'd0);
    chk("tp_emitted", 16'(emitted - base), 16'd128);
    if (emitted - base == 128)
      chk("tp_consecutive", 16'(emit_at[base + 127] - emit_at[base]), 16'd127);

    // Reset with two items in flight
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = dirv[c + 1].x; b = dirv[c + 1].y;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_mid_product", product, 16'h0000);
    send_one(16'h3F80, 16'h4000, 16'h4000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
